// File: rtl/chopper_gate_driver.sv
// rtl/chopper_gate_driver.sv - dead-time insertion and latched-fault gate driver for one H-bridge
// Two independent legs (index 0 = A, 1 = B) share the dead-time register and the fault latch.
module chopper_gate_driver #(
  parameter int DT_WIDTH   = 8,
  parameter int DT_DEFAULT = 50
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic                pwm_a_pwm,
  input  logic                pwm_b_pwm,
  input  logic                pwm_secure,
  input  logic                fault_clear,
  input  logic [DT_WIDTH-1:0] dt_cycles,
  output logic                gate_a_hi,
  output logic                gate_a_lo,
  output logic                gate_b_hi,
  output logic                gate_b_lo,
  output logic                fault_latched,
  output logic [1:0]          leg_a_state,
  output logic [1:0]          leg_b_state
);

  typedef enum logic [1:0] {
    ST_BLANK = 2'b00,
    ST_HI    = 2'b01,
    ST_LO    = 2'b10
  } leg_state_t;

  localparam logic [DT_WIDTH-1:0] C_ONE    = DT_WIDTH'(1);
  localparam logic [DT_WIDTH-1:0] C_MAX    = '1;
  localparam logic [DT_WIDTH-1:0] C_DT_DEF = (DT_DEFAULT == 0) ? C_ONE : DT_WIDTH'(DT_DEFAULT);

  logic [1:0]          r_sync_a, r_sync_b, r_sync_sec, r_rdy;
  logic                r_fault;
  logic [DT_WIDTH-1:0] r_dt_q;
  leg_state_t          r_state [2];
  logic [DT_WIDTH-1:0] r_cnt   [2];
  logic [1:0]          r_gate_hi, r_gate_lo;

  logic [1:0]          w_cmd;
  logic                w_sec, w_force;
  logic [DT_WIDTH-1:0] w_dt_eff;
  leg_state_t          w_state_nxt [2];
  logic [DT_WIDTH-1:0] w_cnt_nxt   [2];

  assign w_cmd = {r_sync_b[1], r_sync_a[1]};
  assign w_sec = r_sync_sec[1];

  always_comb begin
    w_dt_eff = (dt_cycles == '0) ? C_DT_DEF : dt_cycles;
  end

  // r_rdy keeps the legs parked until the command synchronisers hold valid data.
  always_comb begin
    w_force = r_fault | w_sec | ~r_rdy[1];
    for (int i = 0; i < 2; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
      if (w_force) begin
        w_state_nxt[i] = ST_BLANK;
        w_cnt_nxt[i]   = '0;
      end else begin
        case (r_state[i])
          ST_BLANK: begin
            // >= rather than == so a dt_q shrunk mid-blank cannot strand the leg.
            if (r_cnt[i] >= r_dt_q - C_ONE) begin
              w_state_nxt[i] = w_cmd[i] ? ST_HI : ST_LO;
            end else if (r_cnt[i] != C_MAX) begin
              w_cnt_nxt[i] = r_cnt[i] + C_ONE;
            end
          end
          ST_HI: begin
            if (!w_cmd[i]) begin
              w_state_nxt[i] = ST_BLANK;
              w_cnt_nxt[i]   = '0;
            end
          end
          ST_LO: begin
            if (w_cmd[i]) begin
              w_state_nxt[i] = ST_BLANK;
              w_cnt_nxt[i]   = '0;
            end
          end
          default: begin
            w_state_nxt[i] = ST_BLANK;
            w_cnt_nxt[i]   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_sync_a   <= '0;
      r_sync_b   <= '0;
      r_sync_sec <= '0;
      r_rdy      <= '0;
      r_fault    <= 1'b0;
      r_dt_q     <= C_DT_DEF;
      r_gate_hi  <= '0;
      r_gate_lo  <= '0;
      for (int i = 0; i < 2; i++) begin
        r_state[i] <= ST_BLANK;
        r_cnt[i]   <= '0;
      end
    end else begin
      r_sync_a   <= {r_sync_a[0], pwm_a_pwm};
      r_sync_b   <= {r_sync_b[0], pwm_b_pwm};
      r_sync_sec <= {r_sync_sec[0], pwm_secure};
      r_rdy      <= {r_rdy[0], 1'b1};
      if (w_sec) begin
        r_fault <= 1'b1;
      end else if (fault_clear) begin
        r_fault <= 1'b0;
      end
      if (r_state[0] == ST_BLANK && r_state[1] == ST_BLANK) begin
        r_dt_q <= w_dt_eff;
      end
      for (int i = 0; i < 2; i++) begin
        r_state[i]   <= w_state_nxt[i];
        r_cnt[i]     <= w_cnt_nxt[i];
        r_gate_hi[i] <= (w_state_nxt[i] == ST_HI);
        r_gate_lo[i] <= (w_state_nxt[i] == ST_LO);
      end
    end
  end

  assign gate_a_hi     = r_gate_hi[0];
  assign gate_a_lo     = r_gate_lo[0];
  assign gate_b_hi     = r_gate_hi[1];
  assign gate_b_lo     = r_gate_lo[1];
  assign fault_latched = r_fault;
  assign leg_a_state   = r_state[0];
  assign leg_b_state   = r_state[1];

endmodule
